// File: rtl/spi_prog_master.sv
// Host-side initiator for the processor's serial programming/run port: 12-bit LSB-first
// cache-write frames and the run/done handshake. Define RUN_TIMEOUT_EN for the run watchdog.
module spi_prog_master #(
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid_in,
    output logic       cmd_ready_out,
    input  logic [1:0] cmd_type_in,
    input  logic [3:0] cmd_addr_in,
    input  logic [7:0] cmd_data_in,
    input  logic       proc_done_in,
    output logic [1:0] sel_out,
    output logic       mosi_out,
    output logic       busy_out,
    output logic       run_done_out,
    output logic       timeout_out
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT    = 3'd1,
        GAP      = 3'd2,
        RUN_ARM  = 3'd3,
        RUN_WAIT = 3'd4
    } state_t;

    localparam logic [3:0] LAST_BIT  = 4'd11;
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [1:0] SEL_IDLE  = 2'b00;
    localparam logic [1:0] SEL_INSTR = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_RUN   = 2'b11;

    generate
        if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || TIMEOUT < 1) begin : g_param_check
            $error("spi_prog_master: GAP_CYCLES must be 1..15 and TIMEOUT at least 1");
        end
    endgenerate

    state_t      state_r, state_s;
    logic [10:0] shreg_r, shreg_s;
    logic [3:0]  bit_r, bit_s;
    logic [3:0]  gap_r, gap_s;
    logic [1:0]  sel_r, sel_s;
    logic        mosi_r, mosi_s;
    logic        accept_s;
    logic        expired_s;
    logic        run_done_s;
    logic        timeout_s;

    assign cmd_ready_out = (state_r == IDLE) && !rst;
    assign accept_s      = cmd_valid_in && cmd_ready_out;
    assign busy_out      = (state_r != IDLE);
    assign sel_out       = sel_r;
    assign mosi_out      = mosi_r;
    assign run_done_out  = run_done_s;
    assign timeout_out   = timeout_s;

`ifdef RUN_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    logic [TW-1:0] tmr_r, tmr_s;

    // Watchdog count: zero outside a run, so it starts from zero on entry to RUN_ARM
    always_comb begin
        tmr_s = '0;
        if (state_r == RUN_ARM || state_r == RUN_WAIT) begin
            tmr_s = tmr_r + TMR_ONE;
        end else begin
            tmr_s = '0;
        end
    end

    assign expired_s = (state_r == RUN_ARM || state_r == RUN_WAIT) && (tmr_r == TMO_LAST);

    // Watchdog register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_r <= '0;
        end else begin
            tmr_r <= tmr_s;
        end
    end
`else
    assign expired_s = 1'b0;
`endif

    // Next-state and next-output decode; sel/mosi are computed one cycle ahead and registered
    always_comb begin
        state_s    = state_r;
        shreg_s    = shreg_r;
        bit_s      = bit_r;
        gap_s      = gap_r;
        sel_s      = sel_r;
        mosi_s     = 1'b0;
        run_done_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                sel_s = SEL_IDLE;
                if (accept_s) begin
                    case (cmd_type_in)
                        2'b00, 2'b01: begin
                            state_s = SHIFT;
                            sel_s   = (cmd_type_in == 2'b00) ? SEL_INSTR : SEL_DATA;
                            shreg_s = {cmd_data_in, cmd_addr_in[3:1]};
                            mosi_s  = cmd_addr_in[0];
                            bit_s   = 4'd0;
                        end
                        2'b10: begin
                            state_s = RUN_ARM;
                            sel_s   = SEL_RUN;
                        end
                        default: begin
                            state_s = IDLE;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (bit_r == LAST_BIT) begin
                    state_s = GAP;
                    sel_s   = SEL_IDLE;
                    gap_s   = 4'd0;
                end else begin
                    bit_s   = bit_r + 4'd1;
                    mosi_s  = shreg_r[0];
                    shreg_s = {1'b0, shreg_r[10:1]};
                end
            end
            GAP: begin
                sel_s = SEL_IDLE;
                if (gap_r == GAP_LAST) begin
                    state_s = IDLE;
                end else begin
                    gap_s = gap_r + 4'd1;
                end
            end
            RUN_ARM: begin
                if (expired_s) begin
                    timeout_s = 1'b1;
                    state_s   = GAP;
                    sel_s     = SEL_IDLE;
                    gap_s     = 4'd0;
                end else if (!proc_done_in) begin
                    state_s = RUN_WAIT;
                end else begin
                    state_s = RUN_ARM;
                end
            end
            RUN_WAIT: begin
                // Watchdog wins a same-cycle tie with done so only one pulse is ever raised
                if (expired_s) begin
                    timeout_s = 1'b1;
                    state_s   = GAP;
                    sel_s     = SEL_IDLE;
                    gap_s     = 4'd0;
                end else if (proc_done_in) begin
                    run_done_s = 1'b1;
                    state_s    = GAP;
                    sel_s      = SEL_IDLE;
                    gap_s      = 4'd0;
                end else begin
                    state_s = RUN_WAIT;
                end
            end
            default: begin
                state_s = IDLE;
                sel_s   = SEL_IDLE;
            end
        endcase
    end

    // State and registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            shreg_r <= 11'd0;
            bit_r   <= 4'd0;
            gap_r   <= 4'd0;
            sel_r   <= SEL_IDLE;
            mosi_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            bit_r   <= bit_s;
            gap_r   <= gap_s;
            sel_r   <= sel_s;
            mosi_r  <= mosi_s;
        end
    end
endmodule
